// File: rtl/tremolo_block_sequencer_if.sv
// Block-transfer and core-side signal bundle for the tremolo block sequencer.
// Latency: none, wiring only.
// Backpressure: upstream waits on ready_for_data; the output block is held while next_module_ready is low.
interface tremolo_block_sequencer_if #(
  parameter int BLOCK_SIZE = 32,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 32
);
  logic                         prev_module_done;
  logic [ADDR_W-1:0]            address_in;
  logic [BLOCK_SIZE*DATA_W-1:0] audio_in_blk;
  logic                         next_module_ready;
  logic                         ready_for_data;
  logic                         done;
  logic [ADDR_W-1:0]            address_out;
  logic [BLOCK_SIZE*DATA_W-1:0] audio_out_blk;
  logic                         core_en;
  logic [DATA_W-1:0]            core_audio_in;
  logic [DATA_W-1:0]            core_audio_out;

  // Sequencer side
  modport slave (
    input  prev_module_done, address_in, audio_in_blk, next_module_ready, core_audio_out,
    output ready_for_data, done, address_out, audio_out_blk, core_en, core_audio_in
  );

  // Environment side: upstream stage, downstream stage and tremolo core
  modport master (
    output prev_module_done, address_in, audio_in_blk, next_module_ready, core_audio_out,
    input  ready_for_data, done, address_out, audio_out_blk, core_en, core_audio_in
  );
endinterface

// File: rtl/tremolo_block_sequencer.sv
// Streams one captured sample block through the tremolo core and reassembles the results into a tagged output block.
// Latency: done rises BLOCK_SIZE+PIPE_LAT edges after acceptance (BLOCK_SIZE with bypass under TREMOLO_SEQ_BYPASS_EN).
// Backpressure: a new block is taken only in IDLE; the finished block is held in DONE until next_module_ready.
module tremolo_block_sequencer #(
  parameter int BLOCK_SIZE = 32,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 32,
  parameter int PIPE_LAT   = 1
) (
  input logic clk,
  input logic rst_n,
  tremolo_block_sequencer_if.slave bus
`ifdef TREMOLO_SEQ_BYPASS_EN
  ,
  input logic bypass
`endif
);
  localparam int IDX_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int CNT_W = IDX_W + 1;
  localparam int CH    = (PIPE_LAT > 0) ? PIPE_LAT : 1;
  localparam int BLK_W = BLOCK_SIZE * DATA_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cap_cnt_q, cap_cnt_d;
  logic [BLK_W-1:0]  buf_q, buf_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic [ADDR_W-1:0] addr_out_q, addr_out_d;
  logic [BLK_W-1:0]  out_blk_q, out_blk_d;
  logic              core_en_q, core_en_d;
  logic [DATA_W-1:0] core_in_q, core_in_d;
  logic              byp_q, byp_d;
  logic [CH-1:0]     pv_q, pv_d;
  logic [IDX_W-1:0]  pi_q [CH];
  logic [IDX_W-1:0]  pi_d [CH];

  logic              byp_in;
  logic              cap_vld;
  logic [IDX_W-1:0]  cap_idx;
  logic [IDX_W-1:0]  nxt_idx;

`ifdef TREMOLO_SEQ_BYPASS_EN
  assign byp_in = bypass;
`else
  assign byp_in = 1'b0;
`endif

  assign nxt_idx = idx_q + 1'b1;

  // Capture point: the issued sample itself when the core is combinational, else the tail of the tracking chain
  always_comb begin
    cap_vld = core_en_q;
    cap_idx = idx_q;
    if (PIPE_LAT > 0) begin
      cap_vld = pv_q[CH-1];
      cap_idx = pi_q[CH-1];
    end
  end

  // Next-state, sample issue, result capture and tag handoff
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cap_cnt_d  = cap_cnt_q;
    buf_d      = buf_q;
    tag_d      = tag_q;
    addr_out_d = addr_out_q;
    out_blk_d  = out_blk_q;
    core_en_d  = 1'b0;
    core_in_d  = core_in_q;
    byp_d      = byp_q;

    pv_d[0] = core_en_q;
    pi_d[0] = idx_q;
    for (int i = 1; i < CH; i++) begin
      pv_d[i] = pv_q[i-1];
      pi_d[i] = pi_q[i-1];
    end

    if (cap_vld) begin
      out_blk_d[int'(cap_idx)*DATA_W +: DATA_W] = bus.core_audio_out;
      cap_cnt_d = cap_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.prev_module_done) begin
          buf_d     = bus.audio_in_blk;
          tag_d     = bus.address_in;
          byp_d     = byp_in;
          idx_d     = '0;
          cap_cnt_d = '0;
          core_en_d = ~byp_in;
          core_in_d = bus.audio_in_blk[DATA_W-1:0];
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        // Bypassed blocks skip the core: sample k lands one edge after it is presented
        if (byp_q) begin
          out_blk_d[int'(idx_q)*DATA_W +: DATA_W] = buf_q[int'(idx_q)*DATA_W +: DATA_W];
        end
        if (idx_q == IDX_W'(BLOCK_SIZE - 1)) begin
          idx_d = '0;
          if (byp_q || (PIPE_LAT == 0)) begin
            addr_out_d = tag_q;
            state_d    = S_DONE;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          idx_d     = nxt_idx;
          core_en_d = ~byp_q;
          core_in_d = buf_q[int'(nxt_idx)*DATA_W +: DATA_W];
        end
      end
      S_DRAIN: begin
        if (cap_vld && (cap_cnt_q == CNT_W'(BLOCK_SIZE - 1))) begin
          addr_out_d = tag_q;
          state_d    = S_DONE;
        end
      end
      default: begin
        if (bus.next_module_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously so a partial block is discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cap_cnt_q  <= '0;
      buf_q      <= '0;
      tag_q      <= '0;
      addr_out_q <= '0;
      out_blk_q  <= '0;
      core_en_q  <= 1'b0;
      core_in_q  <= '0;
      byp_q      <= 1'b0;
      pv_q       <= '0;
      for (int i = 0; i < CH; i++) begin
        pi_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cap_cnt_q  <= cap_cnt_d;
      buf_q      <= buf_d;
      tag_q      <= tag_d;
      addr_out_q <= addr_out_d;
      out_blk_q  <= out_blk_d;
      core_en_q  <= core_en_d;
      core_in_q  <= core_in_d;
      byp_q      <= byp_d;
      pv_q       <= pv_d;
      pi_q       <= pi_d;
    end
  end

  assign bus.ready_for_data = (state_q == S_IDLE);
  assign bus.done           = (state_q == S_DONE);
  assign bus.address_out    = addr_out_q;
  assign bus.audio_out_blk  = out_blk_q;
  assign bus.core_en        = core_en_q;
  assign bus.core_audio_in  = core_in_q;
endmodule

// File: tb/tb_tremolo_block_sequencer.sv
// Randomized block-level bench for the tremolo block sequencer with a registered core model.
// Latency: checks done timing, enable window and captured results against a block-level reference.
// Backpressure: holds the output block in DONE for random spans while upstream keeps offering data.
module tb_tremolo_block_sequencer;
  localparam int BS = 32;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int PL = 1;
  localparam int BW = BS * DW;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  tremolo_block_sequencer_if #(.BLOCK_SIZE(BS), .DATA_W(DW), .ADDR_W(AW)) bus ();

`ifdef TREMOLO_SEQ_BYPASS_EN
  logic bypass = 1'b0;
`endif

  tremolo_block_sequencer #(.BLOCK_SIZE(BS), .DATA_W(DW), .ADDR_W(AW), .PIPE_LAT(PL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef TREMOLO_SEQ_BYPASS_EN
    ,
    .bypass(bypass)
`endif
  );

  // Core model, one register deep: mode 0 negates, mode 1 reports the running enable count
  int              lfo_cnt   = 0;
  int              core_mode = 0;
  logic [DW-1:0]   core_q    = '0;
  always @(posedge clk) begin
    if (bus.core_en) begin
      lfo_cnt <= lfo_cnt + 1;
      if (core_mode == 1) core_q <= DW'(lfo_cnt + 1);
      else                core_q <= -bus.core_audio_in;
    end
  end
  assign bus.core_audio_out = core_q;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [DW-1:0] ref_sample(input logic [BW-1:0] blk, input int k,
                                               input int base, input bit byp);
    logic [DW-1:0] s;
    s = blk[k*DW +: DW];
    if (byp) return s;
    if (core_mode == 1) return DW'(base + k + 1);
    return -s;
  endfunction

  function automatic logic [BW-1:0] rand_blk();
    logic [BW-1:0] b;
    for (int k = 0; k < BS; k++) b[k*DW +: DW] = DW'($urandom);
    return b;
  endfunction

  function automatic logic [BW-1:0] ramp_blk();
    logic [BW-1:0] b;
    for (int k = 0; k < BS; k++) b[k*DW +: DW] = DW'(k * 100);
    return b;
  endfunction

  task automatic check_out(input string tag, input logic [BW-1:0] blk, input int base, input bit byp);
    for (int k = 0; k < BS; k++)
      check_val(tag, bus.audio_out_blk[k*DW +: DW], ref_sample(blk, k, base, byp));
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (!bus.ready_for_data && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_val("ready_wait", bus.ready_for_data, 1);
  endtask

  // One full block: accept, stream, wait for done, hold in DONE, release
  task automatic run_block(input logic [BW-1:0] blk, input logic [AW-1:0] addr,
                           input int base, input bit byp, input bit both);
    int m, en_n, first, last, hold;
    wait_ready();
    bus.audio_in_blk     = blk;
    bus.address_in       = addr;
    bus.prev_module_done = 1'b1;
`ifdef TREMOLO_SEQ_BYPASS_EN
    bypass = byp;
`endif
    @(posedge clk);
    @(negedge clk);
    // Upstream keeps chattering during processing; none of it may reach the buffer
    bus.prev_module_done = 1'($urandom_range(0, 1));
    bus.audio_in_blk     = rand_blk();
    bus.address_in       = $urandom;
`ifdef TREMOLO_SEQ_BYPASS_EN
    bypass = 1'($urandom_range(0, 1));
`endif
    m = 0; en_n = 0; first = -1; last = -1;
    while (!bus.done && m < 300) begin
      if (bus.core_en) begin
        en_n++;
        if (first < 0) first = m;
        last = m;
      end
      @(negedge clk);
      m++;
    end
    check_val("done_latency", m, byp ? BS : BS + PL);
    check_val("en_count", en_n, byp ? 0 : BS);
    if (!byp) begin
      check_val("en_first", first, 0);
      check_val("en_last", last, BS - 1);
    end
    check_val("ready_in_done", bus.ready_for_data, 0);
    check_val("addr_out", bus.address_out, addr);
    check_out("out_blk", blk, base, byp);

    bus.next_module_ready = 1'b0;
    hold = $urandom_range(0, 20);
    for (int i = 0; i < hold; i++) begin
      bus.prev_module_done = 1'($urandom_range(0, 1));
      bus.audio_in_blk     = rand_blk();
      @(negedge clk);
      check_val("hold_done", bus.done, 1);
      check_val("hold_ready", bus.ready_for_data, 0);
      check_val("hold_en", bus.core_en, 0);
    end
    check_val("hold_addr", bus.address_out, addr);
    check_out("hold_blk", blk, base, byp);

    bus.prev_module_done  = both;
    bus.next_module_ready = 1'b1;
    @(negedge clk);
    check_val("release_done", bus.done, 0);
    check_val("release_ready", bus.ready_for_data, 1);
    bus.next_module_ready = 1'b0;
    bus.prev_module_done  = 1'b0;
  endtask

  initial begin
    int base;
    rst_n                 = 1'b0;
    bus.prev_module_done  = 1'b0;
    bus.next_module_ready = 1'b0;
    bus.address_in        = '0;
    bus.audio_in_blk      = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_val("rst_ready", bus.ready_for_data, 1);
    check_val("rst_done", bus.done, 0);
    check_val("rst_en", bus.core_en, 0);
    check_val("rst_core_in", bus.core_audio_in, 0);
    check_val("rst_addr", bus.address_out, 0);
    check_val("rst_blk", {63'b0, |bus.audio_out_blk}, 0);

    // Ramp through a negating core
    core_mode = 0;
    run_block(ramp_blk(), 32'h0000_1000, 0, 1'b0, 1'b0);

    // Random blocks, one with upstream and downstream both high in DONE
    for (int b = 0; b < 4; b++)
      run_block(rand_blk(), $urandom, 0, 1'b0, (b == 1));

    // Counting core: consecutive blocks must see an unbroken enable sequence
    core_mode = 1;
    base = lfo_cnt;
    run_block(rand_blk(), $urandom, base, 1'b0, 1'b0);
    run_block(rand_blk(), $urandom, base + BS, 1'b0, 1'b1);
    core_mode = 0;

    // Reset while the block is partway through the core
    wait_ready();
    bus.audio_in_blk     = rand_blk();
    bus.address_in       = $urandom;
    bus.prev_module_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.prev_module_done = 1'b0;
    repeat (12) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("mid_rst_en", bus.core_en, 0);
    check_val("mid_rst_ready", bus.ready_for_data, 1);
    check_val("mid_rst_done", bus.done, 0);
    check_val("mid_rst_core_in", bus.core_audio_in, 0);
    check_val("mid_rst_addr", bus.address_out, 0);
    check_val("mid_rst_blk", {63'b0, |bus.audio_out_blk}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_block(rand_blk(), $urandom, 0, 1'b0, 1'b0);

`ifdef TREMOLO_SEQ_BYPASS_EN
    run_block(ramp_blk(), 32'h0000_2000, 0, 1'b1, 1'b0);
    run_block(ramp_blk(), 32'h0000_1000, 0, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tremolo_block_sequencer.md
Name: tremolo_block_sequencer

Overview:
Block-level controller for the streaming tremolo effect core.
- Accepts one block of BLOCK_SIZE samples from the upstream effect stage via the done/ready handshake.
- Streams the samples into the core one per clock, asserting the core's enable only for real samples so the LFO phase stays continuous across blocks.
- Collects the core's outputs into an output block and presents it downstream with a tag address.

Parameters:
BLOCK_SIZE, 32, samples per block (power of 2, 2..256)
DATA_W, 16, signed sample width
ADDR_W, 32, width of the block tag address
PIPE_LAT, 1, clocks from core en/audio_in to the matching core audio_out (0..4)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
prev_module_done  in  1  upstream block valid; sampled only in IDLE
address_in  in  ADDR_W  block tag, captured with the block
audio_in_blk  in  BLOCK_SIZE*DATA_W  input block; sample k is at bits [k*DATA_W +: DATA_W]
next_module_ready  in  1  downstream has consumed the output block
ready_for_data  out  1  high only in IDLE
done  out  1  output block valid; high only in DONE
address_out  out  ADDR_W  tag of the current output block
audio_out_blk  out  BLOCK_SIZE*DATA_W  processed block, same packing as the input
core_en  out  1  enable to the tremolo core; advances its LFO one step
core_audio_in  out  DATA_W  sample presented to the core
core_audio_out  in  DATA_W  core result

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, idx=0, capture count=0.
  - ready_for_data=1, done=0, core_en=0, core_audio_in=0.
  - address_out=0, audio_out_blk=0, input buffer=0.
- IDLE:
  - On a clock edge (E0) with prev_module_done=1, register audio_in_blk and address_in, then go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - In the cycle after E(k), drive core_audio_in=buffer[k] and core_en=1, for k=0..BLOCK_SIZE-1.
  - idx increments every clock. After the sample k=BLOCK_SIZE-1, go to DRAIN; if PIPE_LAT=0, go directly to DONE.
- Capture:
  - A PIPE_LAT-deep valid/index shift chain tracks each issued sample.
  - Core output for sample k is written to audio_out_blk[k] at edge E(k+PIPE_LAT+1).
  - Capture applies in both RUN and DRAIN.
- DRAIN:
  - core_en=0 and core_audio_in holds its last value.
  - Stay until the last capture edge E(BLOCK_SIZE+PIPE_LAT).
  - On that edge: set done=1, load address_out with the captured tag, go to DONE.
- DONE:
  - done=1, ready_for_data=0; audio_out_blk and address_out are stable.
  - On an edge with next_module_ready=1, go to IDLE (done=0, ready_for_data=1 after that edge).
- Latency: done rises on edge E0+BLOCK_SIZE+PIPE_LAT (33 edges for the defaults). Block-to-block throughput is latency + 2 clocks minimum.
- Boundary conditions:
  - prev_module_done outside IDLE is ignored; the input buffer is not overwritten.
  - next_module_ready outside DONE is ignored.
  - prev_module_done and next_module_ready together in DONE: move to IDLE only; the block is not accepted until an edge in IDLE.
  - prev_module_done held high continuously: a new block is accepted on the first IDLE edge.
  - idx wraps from BLOCK_SIZE-1 to 0 at the end of RUN.
  - core_en is never high outside RUN; the LFO sees exactly BLOCK_SIZE enables per block.
  - Reset mid-RUN or mid-DONE: immediate return to reset values; the partial block is discarded.
- Arithmetic: samples pass through unmodified. No saturation or scaling in this block.

Optional Feature:
TREMOLO_SEQ_BYPASS_EN
- With the macro defined:
  - Adds input port bypass (1 bit), sampled at E0 and held for the block.
  - If bypass=1: RUN copies buffer[k] straight into audio_out_blk[k] at edge E(k+1) and keeps core_en=0, so the LFO phase is frozen. done rises at E0+BLOCK_SIZE and DRAIN is skipped.
  - If bypass=0: identical to the base behaviour.
- Without the macro: no bypass port; always processes through the core.

Test Plan:
1. Reset, then idle 10 clocks → ready_for_data=1, done=0, core_en=0, all outputs 0.
2. Ramp block (sample k=k*100), address_in=0x0000_1000, core model = registered negate (PIPE_LAT=1), 1-clock prev_module_done pulse → core_en high for exactly 32 clocks; done at edge 33; audio_out_blk[k]=-k*100; address_out=0x1000.
3. Hold next_module_ready=0 for 20 clocks in DONE; pulse prev_module_done with a different block → outputs unchanged, ready_for_data=0; after next_module_ready=1, one edge → IDLE.
4. Two consecutive blocks with a counting core model (output = count of en pulses) → second block's outputs are 33..64, proving LFO continuity; no en gaps counted.
5. Assert rst_n=0 at RUN idx=12 → asynchronous clear of all outputs; the next full block processes correctly from idx 0.
6. With TREMOLO_SEQ_BYPASS_EN and bypass=1, ramp block → audio_out_blk equals input, core_en never high, done at edge 32; a following block with bypass=0 matches scenario 2.
